// File: rtl/el2_exu_ffinv_seq_pkg.sv
// Shared types for the GF(2^m) inversion sequencer: FSM states, field codes
// and the op packet handed to the finite-field mul/square unit.
package el2_exu_ffinv_seq_pkg;

  localparam int FF_MAX_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SQR   = 3'd1,
    SW    = 3'd2,
    MUL   = 3'd3,
    MW    = 3'd4,
    DONE  = 3'd5,
    DRAIN = 3'd6
  } el2_ffinv_state_t;

  // FIELD_NONE marks a request whose select was not one-hot
  typedef enum logic [1:0] {
    FIELD1     = 2'd0,
    FIELD2     = 2'd1,
    FIELD3     = 2'd2,
    FIELD_NONE = 2'd3
  } el2_ffinv_field_t;

  typedef struct packed {
    logic valid;
    logic ffsqr3;
    logic ffmul3;
    logic ffsqr2;
    logic ffmul2;
    logic ffsqr1;
    logic ffmul1;
  } el2_mul_pkt_t;

  function automatic logic [FF_MAX_W-1:0] ff_mask(input int m);
    logic [FF_MAX_W-1:0] mask;
    mask = '0;
    for (int i = 0; i < FF_MAX_W; i++) begin
      if (i < m) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/el2_exu_ffinv_seq.sv
// Square-and-multiply sequencer computing a^(2^m-2) = a^-1 in GF(2^m) by
// issuing sqr/mul ops to the shared FF unit, one outstanding op at a time.
module el2_exu_ffinv_seq
  import el2_exu_ffinv_seq_pkg::*;
#(
  parameter int FF1_M = 8,
  parameter int FF2_M = 16,
  parameter int FF3_M = 32
) (
  input  logic                clk,
  input  logic                rst_l,
  input  logic                flush,
  input  logic                inv_valid,
  output logic                inv_ready,
  input  logic [2:0]          inv_sel,
  input  logic [FF_MAX_W-1:0] inv_a,
  output logic                inv_res_valid,
  output logic [FF_MAX_W-1:0] inv_res,
  output logic                inv_err,
  output logic                ff_req_valid,
  input  logic                ff_req_ready,
  output el2_mul_pkt_t        ff_req_pkt,
  output logic [FF_MAX_W-1:0] ff_req_a,
  output logic [FF_MAX_W-1:0] ff_req_b,
  input  logic                ff_rsp_valid,
  input  logic [FF_MAX_W-1:0] ff_rsp_data
);

  localparam logic [FF_MAX_W-1:0] MASK1 = ff_mask(FF1_M);
  localparam logic [FF_MAX_W-1:0] MASK2 = ff_mask(FF2_M);
  localparam logic [FF_MAX_W-1:0] MASK3 = ff_mask(FF3_M);
  localparam logic [4:0]          CNT1  = 5'(FF1_M - 2);
  localparam logic [4:0]          CNT2  = 5'(FF2_M - 2);
  localparam logic [4:0]          CNT3  = 5'(FF3_M - 2);

  el2_ffinv_state_t    state_q, state_d;
  el2_ffinv_field_t    field_q, field_d;
  el2_ffinv_field_t    sel_field;
  logic [FF_MAX_W-1:0] x_q, x_d;
  logic [FF_MAX_W-1:0] acc_q, acc_d;
  logic [FF_MAX_W-1:0] res_q, res_d;
  logic [FF_MAX_W-1:0] sel_mask, field_mask, x_in;
  logic [4:0]          cnt_q, cnt_d, sel_cnt;
  logic                err_q, err_d;
  logic                res_valid_q, res_valid_d;

  // Decode of the incoming select; an invalid select masks the operand to zero
  always_comb begin
    sel_field = FIELD_NONE;
    sel_mask  = '0;
    sel_cnt   = '0;
    case (inv_sel)
      3'b001: begin sel_field = FIELD1; sel_mask = MASK1; sel_cnt = CNT1; end
      3'b010: begin sel_field = FIELD2; sel_mask = MASK2; sel_cnt = CNT2; end
      3'b100: begin sel_field = FIELD3; sel_mask = MASK3; sel_cnt = CNT3; end
      default: ;
    endcase
  end

  assign x_in = inv_a & sel_mask;

  always_comb begin
    field_mask = '0;
    case (field_q)
      FIELD1:  field_mask = MASK1;
      FIELD2:  field_mask = MASK2;
      FIELD3:  field_mask = MASK3;
      default: field_mask = '0;
    endcase
  end

  // Next-state: flush always wins, and an op already accepted by the FF unit
  // must have its response drained before a new request can start
  always_comb begin
    state_d     = state_q;
    field_d     = field_q;
    x_d         = x_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    err_d       = err_q;
    res_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (inv_valid && !flush) begin
          field_d = sel_field;
          x_d     = x_in;
          acc_d   = x_in;
          if (sel_field == FIELD_NONE || x_in[FF_MAX_W-1:1] == '0) begin
            state_d = DONE;
          end else begin
            cnt_d   = sel_cnt;
            state_d = SQR;
          end
        end
      end
      SQR, MUL: begin
        if (ff_req_ready) begin
          if (flush)                 state_d = DRAIN;
          else if (state_q == SQR)   state_d = SW;
          else                       state_d = MW;
        end else if (flush) begin
          state_d = IDLE;
        end
      end
      SW, MW: begin
        if (flush) begin
          state_d = ff_rsp_valid ? IDLE : DRAIN;
        end else if (ff_rsp_valid) begin
          acc_d = ff_rsp_data & field_mask;
          if (state_q == MW) begin
            if (cnt_q != 5'd0) cnt_d = cnt_q - 5'd1;
            state_d = SQR;
          end else begin
            state_d = (cnt_q == 5'd0) ? DONE : MUL;
          end
        end
      end
      DONE: begin
        res_valid_d = !flush;
        err_d       = (field_q == FIELD_NONE);
        res_d       = (field_q == FIELD_NONE) ? '0 : acc_q;
        state_d     = IDLE;
      end
      DRAIN: begin
        if (ff_rsp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= IDLE;
      field_q     <= FIELD1;
      x_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      res_q       <= '0;
      err_q       <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      field_q     <= field_d;
      x_q         <= x_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      err_q       <= err_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign inv_ready     = (state_q == IDLE);
  assign inv_res_valid = res_valid_q & ~flush;
  assign inv_res       = res_q;
  assign inv_err       = err_q;
  assign ff_req_valid  = (state_q == SQR) || (state_q == MUL);

  // Request fields come straight from registers, so they hold until accepted
  always_comb begin
    ff_req_pkt = '0;
    ff_req_a   = '0;
    ff_req_b   = '0;
    if (state_q == SQR) begin
      ff_req_pkt.valid  = 1'b1;
      ff_req_pkt.ffsqr1 = (field_q == FIELD1);
      ff_req_pkt.ffsqr2 = (field_q == FIELD2);
      ff_req_pkt.ffsqr3 = (field_q == FIELD3);
      ff_req_a          = acc_q;
      ff_req_b          = acc_q;
    end else if (state_q == MUL) begin
      ff_req_pkt.valid  = 1'b1;
      ff_req_pkt.ffmul1 = (field_q == FIELD1);
      ff_req_pkt.ffmul2 = (field_q == FIELD2);
      ff_req_pkt.ffmul3 = (field_q == FIELD3);
      ff_req_a          = acc_q;
      ff_req_b          = x_q;
    end
  end

endmodule

// File: tb/tb_el2_exu_ffinv_seq.sv
// Directed bench for el2_exu_ffinv_seq with a GF(2^m) FF-unit model
// (response latency 2, optional random or forced ready stalls).
module tb_el2_exu_ffinv_seq;
  import el2_exu_ffinv_seq_pkg::*;

  logic         clk = 1'b0;
  logic         rst_l = 1'b0;
  logic         flush = 1'b0;
  logic         inv_valid = 1'b0;
  logic [2:0]   inv_sel = 3'b000;
  logic [31:0]  inv_a = 32'h0;
  logic         inv_ready;
  logic         inv_res_valid;
  logic [31:0]  inv_res;
  logic         inv_err;
  logic         ff_req_valid;
  logic         ff_req_ready = 1'b1;
  el2_mul_pkt_t ff_req_pkt;
  logic [31:0]  ff_req_a;
  logic [31:0]  ff_req_b;
  logic         ff_rsp_valid = 1'b0;
  logic [31:0]  ff_rsp_data = 32'h0;

  int n_checks = 0;
  int n_fails  = 0;

  int           op_count = 0;
  bit           sqr_hist [64];
  logic [31:0]  first_a = 32'h0;
  el2_mul_pkt_t first_pkt = '0;
  bit           stall_rand = 1'b0;
  int           hold_cnt = 0;
  bit           holding = 1'b0;
  logic [70:0]  held_req = '0;
  int           pend = 0;
  logic [31:0]  pend_data = 32'h0;
  int           res_strobes = 0;

  logic [31:0]  got_res;
  logic         got_err;

  el2_exu_ffinv_seq dut (
    .clk           (clk),
    .rst_l         (rst_l),
    .flush         (flush),
    .inv_valid     (inv_valid),
    .inv_ready     (inv_ready),
    .inv_sel       (inv_sel),
    .inv_a         (inv_a),
    .inv_res_valid (inv_res_valid),
    .inv_res       (inv_res),
    .inv_err       (inv_err),
    .ff_req_valid  (ff_req_valid),
    .ff_req_ready  (ff_req_ready),
    .ff_req_pkt    (ff_req_pkt),
    .ff_req_a      (ff_req_a),
    .ff_req_b      (ff_req_b),
    .ff_rsp_valid  (ff_rsp_valid),
    .ff_rsp_data   (ff_rsp_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] gf_mul(input logic [31:0] a, input logic [31:0] b,
                                         input int m, input logic [32:0] poly);
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < 32; i++) begin
      if (b[i]) p = p ^ ({32'h0, a} << i);
    end
    for (int i = 62; i >= m; i--) begin
      if (p[i]) p = p ^ ({31'h0, poly} << (i - m));
    end
    return p[31:0];
  endfunction

  function automatic logic [31:0] ff_model(input el2_mul_pkt_t p, input logic [31:0] a,
                                           input logic [31:0] b);
    if (p.ffsqr1 || p.ffmul1) return gf_mul(a, b, 8, 33'h11B);
    if (p.ffsqr2 || p.ffmul2) return gf_mul(a, b, 16, 33'h1002B);
    return gf_mul(a, b, 32, 33'h1_0000_008D);
  endfunction

  // FF unit model: acts just after each rising edge, answers 2 cycles after accept
  initial forever begin
    @(posedge clk);
    #1;
    if (inv_res_valid) res_strobes++;
    ff_rsp_valid = 1'b0;
    if (pend == 2) begin
      ff_rsp_valid = 1'b1;
      ff_rsp_data  = pend_data;
      pend = 0;
    end else if (pend == 1) begin
      pend = 2;
    end
    if (ff_req_valid && holding)
      checkOutput("req_stable", 80'({ff_req_pkt, ff_req_a, ff_req_b}), 80'(held_req));
    if (ff_req_valid && hold_cnt > 0) begin
      if (!holding) held_req = {ff_req_pkt, ff_req_a, ff_req_b};
      holding = 1'b1;
      ff_req_ready = 1'b0;
      hold_cnt--;
    end else begin
      ff_req_ready = stall_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    if (ff_req_valid && ff_req_ready) begin
      holding = 1'b0;
      if (op_count < 64) sqr_hist[op_count] = ff_req_pkt.ffsqr1 | ff_req_pkt.ffsqr2 | ff_req_pkt.ffsqr3;
      if (op_count == 0) begin
        first_a   = ff_req_a;
        first_pkt = ff_req_pkt;
      end
      op_count++;
      pend      = 1;
      pend_data = ff_model(ff_req_pkt, ff_req_a, ff_req_b);
    end
  end

  // Issue one request from a falling edge and wait (bounded) for its result strobe
  task automatic applyStimulus(input logic [2:0] sel, input logic [31:0] a, output int lat);
    int guard;
    guard = 0;
    while (!inv_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    op_count  = 0;
    inv_valid = 1'b1;
    inv_sel   = sel;
    inv_a     = a;
    @(negedge clk);
    inv_valid = 1'b0;
    lat = 1;
    while (!inv_res_valid && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("res_valid_seen", 80'(inv_res_valid), 80'(1'b1));
    got_res = inv_res;
    got_err = inv_err;
  endtask

  initial begin
    int lat;
    int guard;
    int strobes0;
    el2_mul_pkt_t exp_pkt;

    $display("[TB] start");
    repeat (2) @(negedge clk);
    checkOutput("rst_inv_ready", 80'(inv_ready), 80'(1'b1));
    checkOutput("rst_res_valid", 80'(inv_res_valid), 80'(1'b0));
    checkOutput("rst_res", 80'(inv_res), 80'(32'h0));
    checkOutput("rst_err", 80'(inv_err), 80'(1'b0));
    checkOutput("rst_req_valid", 80'(ff_req_valid), 80'(1'b0));
    checkOutput("rst_req_pkt", 80'(ff_req_pkt), 80'(7'h0));
    checkOutput("rst_req_ab", 80'({ff_req_a, ff_req_b}), 80'(64'h0));
    rst_l = 1'b1;
    @(negedge clk);

    $display("[TB] ffinv1 0x53 with ready held high");
    applyStimulus(3'b001, 32'h53, lat);
    checkOutput("inv53_res", 80'(got_res), 80'(32'hCA));
    checkOutput("inv53_err", 80'(got_err), 80'(1'b0));
    checkOutput("inv53_ops", 80'(op_count), 80'(13));
    checkOutput("inv53_lat", 80'(lat), 80'(41));
    for (int i = 0; i < 13; i++)
      checkOutput($sformatf("inv53_op%0d_is_sqr", i), 80'(sqr_hist[i]), 80'((i % 2) == 0));

    $display("[TB] trivial operands 0 and 1");
    applyStimulus(3'b001, 32'h0, lat);
    checkOutput("inv0_res", 80'(got_res), 80'(32'h0));
    checkOutput("inv0_lat", 80'(lat), 80'(2));
    checkOutput("inv0_ops", 80'(op_count), 80'(0));
    applyStimulus(3'b001, 32'h1, lat);
    checkOutput("inv1_res", 80'(got_res), 80'(32'h1));
    checkOutput("inv1_lat", 80'(lat), 80'(2));
    checkOutput("inv1_ops", 80'(op_count), 80'(0));

    $display("[TB] invalid selects");
    applyStimulus(3'b011, 32'h53, lat);
    checkOutput("sel011_err", 80'(got_err), 80'(1'b1));
    checkOutput("sel011_res", 80'(got_res), 80'(32'h0));
    checkOutput("sel011_ops", 80'(op_count), 80'(0));
    checkOutput("sel011_lat", 80'(lat), 80'(2));
    applyStimulus(3'b000, 32'h53, lat);
    checkOutput("sel000_err", 80'(got_err), 80'(1'b1));

    $display("[TB] upper operand bits masked, random ready stalls");
    stall_rand = 1'b1;
    applyStimulus(3'b001, 32'hFFFFFF53, lat);
    checkOutput("invmask_res", 80'(got_res), 80'(32'hCA));
    checkOutput("invmask_err", 80'(got_err), 80'(1'b0));
    checkOutput("invmask_ops", 80'(op_count), 80'(13));
    stall_rand = 1'b0;

    $display("[TB] ready held low for 7 cycles on the first op");
    hold_cnt = 7;
    applyStimulus(3'b001, 32'h53, lat);
    checkOutput("hold_res", 80'(got_res), 80'(32'hCA));
    checkOutput("hold_lat", 80'(lat), 80'(48));
    checkOutput("hold_consumed", 80'(hold_cnt), 80'(0));

    $display("[TB] flush while waiting on the sixth op");
    op_count  = 0;
    inv_valid = 1'b1;
    inv_sel   = 3'b001;
    inv_a     = 32'h53;
    @(negedge clk);
    inv_valid = 1'b0;
    guard = 0;
    while (op_count < 6 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("flush_reached_op6", 80'(op_count), 80'(6));
    checkOutput("flush_op6_is_mul", 80'(ff_req_pkt.ffmul1), 80'(1'b1));
    @(negedge clk);
    strobes0 = res_strobes;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("drain_ready_low", 80'(inv_ready), 80'(1'b0));
    @(negedge clk);
    checkOutput("drain_ready_back", 80'(inv_ready), 80'(1'b1));
    repeat (3) @(negedge clk);
    checkOutput("flush_no_result", 80'(res_strobes - strobes0), 80'(0));
    checkOutput("flush_no_new_ops", 80'(op_count), 80'(6));
    applyStimulus(3'b001, 32'h02, lat);
    checkOutput("inv02_res", 80'(got_res), 80'(32'h8D));
    checkOutput("inv02_err", 80'(got_err), 80'(1'b0));

    $display("[TB] ffinv2 and ffinv3 schedules");
    applyStimulus(3'b010, 32'hFFFF1234, lat);
    exp_pkt = '0;
    exp_pkt.valid  = 1'b1;
    exp_pkt.ffsqr2 = 1'b1;
    checkOutput("f2_ops", 80'(op_count), 80'(29));
    checkOutput("f2_first_a", 80'(first_a), 80'(32'h1234));
    checkOutput("f2_first_pkt", 80'(first_pkt), 80'(exp_pkt));
    checkOutput("f2_res_upper", 80'(got_res[31:16]), 80'(16'h0));
    checkOutput("f2_lat", 80'(lat), 80'(89));
    applyStimulus(3'b100, 32'h2, lat);
    checkOutput("f3_ops", 80'(op_count), 80'(61));
    checkOutput("f3_lat", 80'(lat), 80'(185));
    checkOutput("f3_err", 80'(got_err), 80'(1'b0));

    $display("[TB] async reset while waiting on a square response");
    op_count  = 0;
    inv_valid = 1'b1;
    inv_sel   = 3'b001;
    inv_a     = 32'h53;
    @(negedge clk);
    inv_valid = 1'b0;
    guard = 0;
    while (op_count < 3 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("rstmid_reached_op3", 80'(op_count), 80'(3));
    @(negedge clk);
    strobes0 = res_strobes;
    rst_l = 1'b0;
    #1;
    checkOutput("rstmid_inv_ready", 80'(inv_ready), 80'(1'b1));
    checkOutput("rstmid_res_valid", 80'(inv_res_valid), 80'(1'b0));
    checkOutput("rstmid_res", 80'(inv_res), 80'(32'h0));
    checkOutput("rstmid_err", 80'(inv_err), 80'(1'b0));
    checkOutput("rstmid_req_valid", 80'(ff_req_valid), 80'(1'b0));
    checkOutput("rstmid_req_pkt", 80'(ff_req_pkt), 80'(7'h0));
    checkOutput("rstmid_req_ab", 80'({ff_req_a, ff_req_b}), 80'(64'h0));
    @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
    checkOutput("stray_rsp_ready", 80'(inv_ready), 80'(1'b1));
    checkOutput("stray_rsp_req_valid", 80'(ff_req_valid), 80'(1'b0));
    checkOutput("stray_rsp_no_result", 80'(res_strobes - strobes0), 80'(0));
    stall_rand = 1'b1;
    applyStimulus(3'b001, 32'h53, lat);
    checkOutput("post_rst_res", 80'(got_res), 80'(32'hCA));
    checkOutput("post_rst_err", 80'(got_err), 80'(1'b0));
    stall_rand = 1'b0;

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
